// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding and FSM states.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiplier and restoring divider sharing one 2*WIDTH accumulator.
// One bit per cycle, then a sign-fix cycle; results land in registered hi/lo.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 op_is_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH:0]       mul_sum, div_rem, div_diff;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = op_signed & a[WIDTH-1];
    b_neg     = op_signed & b[WIDTH-1];
    abs_a     = a_neg ? -a : a;
    abs_b     = b_neg ? -b : b;

    // Shift-add: add multiplicand into the upper half when the low bit is set, then shift right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mul_step  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                         : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring divide: remainder in the upper half, dividend shifts out / quotient shifts in.
    div_rem   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_rem - {1'b0, opnd_q};
    div_step  = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo_fix   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op_is_div && (b == '0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            state_d   = op_is_div ? StDiv : StMul;
            acc_d     = {{WIDTH{1'b0}}, abs_a};
            opnd_d    = abs_b;
            cnt_d     = '0;
            is_div_d  = op_is_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      StMul: begin
        acc_d = mul_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StDiv: begin
        acc_d = div_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
